// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the RV32I register file with hazard scoreboard.
package rf_pkg;

  // The clear engine is either idle or walking through the register array.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // Register 0 is hardwired to zero and is never written or marked pending.
  localparam int RF_ZERO_IDX = 0;

  localparam int RF_DEF_WIDTH      = 32;
  localparam int RF_DEF_ADDR_WIDTH = 5;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between the pipeline (decode/issue/write-back) and the register file.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int WIDTH      = RF_DEF_WIDTH,
  parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2
);

  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]      rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [WIDTH-1:0]             wr_data;
  logic                         iss_en;
  logic [ADDR_WIDTH-1:0]        iss_addr;
  logic                         clr_start;
  logic                         clr_busy;

  // The pipeline drives indices and strobes.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_start,
    input  rd_data, rd_busy, clr_busy
  );

  // The register file answers with read data and hazard/clear status.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_start,
    output rd_data, rd_busy, clr_busy
  );

endinterface

// File: rtl/reg_file_sb_read_port.sv
// One combinational read port: x0 handling, write-back forwarding and hazard flag.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH      = RF_DEF_WIDTH,
  parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      stored_data,
  input  logic                  pending_bit,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  fwd_en,
  input  logic                  busy_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_busy
);

  logic fwd_hit;

  // Forwarding applies only when enabled, in normal operation, and on a nonzero index match.
  always_comb begin
    fwd_hit = 1'b0;
    if (BYPASS != 0) begin
      fwd_hit = fwd_en && wr_en && (wr_addr == rd_addr);
    end
  end

  // x0 reads zero and never stalls; forwarded data is fresh so it never stalls either.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_addr == ADDR_WIDTH'(RF_ZERO_IDX)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (fwd_hit) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end else begin
      rd_data = stored_data;
      rd_busy = pending_bit && busy_en;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with write-back bypass, pending
// scoreboard and a one-register-per-cycle soft-clear engine.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int WIDTH      = RF_DEF_WIDTH,
  parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_sb_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt, cnt_d;

  logic                  in_clear;
  logic                  clr_go;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  fwd_en;
  logic                  busy_en;

  logic [WIDTH-1:0]      port_data [NUM_RD];
  logic [NUM_RD-1:0]     port_busy;

  // Qualify the pipeline strobes: the clear engine owns the array while it runs.
  always_comb begin
    in_clear = (state_q == CLEAR);
    clr_go   = (state_q == IDLE) && bus.clr_start;
    wr_ok    = !in_clear && bus.wr_en  && (bus.wr_addr  != ADDR_WIDTH'(RF_ZERO_IDX));
    iss_ok   = !in_clear && bus.iss_en && (bus.iss_addr != ADDR_WIDTH'(RF_ZERO_IDX));
    fwd_en   = reset && !in_clear;
    busy_en  = !in_clear;
  end

  // Clear-engine state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= cnt_d;
    end
  end

  // Next-state logic: start at index 1 (x0 is already zero) and stop after the top index.
  always_comb begin
    state_d      = state_q;
    cnt_d        = clr_cnt;
    bus.clr_busy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = ADDR_WIDTH'(1);
        end
      end
      CLEAR: begin
        bus.clr_busy = 1'b1;
        cnt_d        = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register array: the clear sweep takes priority, otherwise accept write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (in_clear) begin
      regs[clr_cnt] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard: write-back retires, issue marks pending; issue is applied last so the newer producer wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else if (clr_go) begin
      pending <= '0;
    end else begin
      if (wr_ok) begin
        pending[bus.wr_addr] <= 1'b0;
      end
      if (iss_ok) begin
        pending[bus.iss_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    rf_read_port #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
    ) u_port (
      .rd_addr     (addr),
      .stored_data (regs[addr]),
      .pending_bit (pending[addr]),
      .wr_en       (bus.wr_en),
      .wr_addr     (bus.wr_addr),
      .wr_data     (bus.wr_data),
      .fwd_en      (fwd_en),
      .busy_en     (busy_en),
      .rd_data     (port_data[k]),
      .rd_busy     (port_busy[k])
    );
  end

  // Pack the per-port results onto the bus.
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*WIDTH +: WIDTH] = port_data[k];
    end
    bus.rd_busy = port_busy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a BYPASS=1 and a BYPASS=0 instance
// share the same stimulus; expectations go through a scoreboard queue.
module tb_reg_file_sb;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_RD     = 2;

  typedef struct {
    string       name;
    logic [4:0]  rd0, rd1;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ien;
    logic [4:0]  iaddr;
    logic        clr;
    logic [31:0] d0, d1;
    logic        b0, b1, cb;
    logic [31:0] nd0, nd1;
    logic        nb0, nb1;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] d0, d1, nd0, nd1;
    logic        b0, b1, nb0, nb1, cb;
  } exp_t;

  logic clk;
  logic reset;

  int   n_vec;
  int   n_miss;
  exp_t sb_q[$];
  vec_t tbl[$];

  reg_file_sb_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)) bp_if ();
  reg_file_sb_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)) nb_if ();

  reg_file_sb #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD), .BYPASS(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bp_if)
  );

  reg_file_sb #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD), .BYPASS(0)) u_dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (nb_if)
  );

  assign nb_if.rd_addr   = bp_if.rd_addr;
  assign nb_if.wr_en     = bp_if.wr_en;
  assign nb_if.wr_addr   = bp_if.wr_addr;
  assign nb_if.wr_data   = bp_if.wr_data;
  assign nb_if.iss_en    = bp_if.iss_en;
  assign nb_if.iss_addr  = bp_if.iss_addr;
  assign nb_if.clr_start = bp_if.clr_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fillVal(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  function automatic vec_t mk(input string name, input logic [4:0] rd0, input logic [4:0] rd1,
                              input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic ien, input logic [4:0] iaddr, input logic clr,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1, input logic cb);
    vec_t v;
    v.name = name; v.rd0 = rd0; v.rd1 = rd1;
    v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.ien = ien; v.iaddr = iaddr; v.clr = clr;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.cb = cb;
    v.nd0 = d0; v.nd1 = d1; v.nb0 = b0; v.nb1 = b1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    bp_if.rd_addr   = {v.rd1, v.rd0};
    bp_if.wr_en     = v.wen;
    bp_if.wr_addr   = v.waddr;
    bp_if.wr_data   = v.wdata;
    bp_if.iss_en    = v.ien;
    bp_if.iss_addr  = v.iaddr;
    bp_if.clr_start = v.clr;
    e.name = v.name;
    e.d0 = v.d0; e.d1 = v.d1; e.b0 = v.b0; e.b1 = v.b1; e.cb = v.cb;
    e.nd0 = v.nd0; e.nd1 = v.nd1; e.nb0 = v.nb0; e.nb1 = v.nb1;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, fld, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    cmp(e.name, "bp_d0", bp_if.rd_data[31:0],  e.d0);
    cmp(e.name, "bp_d1", bp_if.rd_data[63:32], e.d1);
    cmp(e.name, "bp_b0", 32'(bp_if.rd_busy[0]), 32'(e.b0));
    cmp(e.name, "bp_b1", 32'(bp_if.rd_busy[1]), 32'(e.b1));
    cmp(e.name, "bp_cb", 32'(bp_if.clr_busy),   32'(e.cb));
    cmp(e.name, "nb_d0", nb_if.rd_data[31:0],  e.nd0);
    cmp(e.name, "nb_d1", nb_if.rd_data[63:32], e.nd1);
    cmp(e.name, "nb_b0", 32'(nb_if.rd_busy[0]), 32'(e.nb0));
    cmp(e.name, "nb_b1", 32'(nb_if.rd_busy[1]), 32'(e.nb1));
    cmp(e.name, "nb_cb", 32'(nb_if.clr_busy),   32'(e.cb));
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    bp_if.rd_addr   = '0;
    bp_if.wr_en     = 1'b0;
    bp_if.wr_addr   = '0;
    bp_if.wr_data   = '0;
    bp_if.iss_en    = 1'b0;
    bp_if.iss_addr  = '0;
    bp_if.clr_start = 1'b0;

    // Table of single-cycle vectors; expectations are the values seen before the edge.
    tbl.push_back(mk("rst_hold",   5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("rd5_pre",    5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("wr5",        0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("rd5_post",   5, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
    v = mk("bypass7",              5, 7, 1, 7, 32'h12345678, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 0);
    v.nd1 = 32'h0;
    tbl.push_back(v);
    tbl.push_back(mk("rd7_post",   5, 7, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk("iss3",       3, 0, 0, 0, 32'h0,        1, 3, 0, 32'h0, 32'h0, 0, 0, 0));
    v = mk("wr_iss3",              3, 0, 1, 3, 32'hAAAA5555, 1, 3, 0, 32'hAAAA5555, 32'h0, 0, 0, 0);
    v.nd0 = 32'h0; v.nb0 = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk("rd3_busy",   3, 0, 0, 0, 32'h0,        0, 0, 0, 32'hAAAA5555, 32'h0, 1, 0, 0));
    v = mk("wr3_lone",             3, 0, 1, 3, 32'h0BADF00D, 0, 0, 0, 32'h0BADF00D, 32'h0, 0, 0, 0);
    v.nd0 = 32'hAAAA5555; v.nb0 = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk("rd3_free",   3, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0BADF00D, 32'h0, 0, 0, 0));
    tbl.push_back(mk("wr_iss_x0",  0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("rd_x0",      0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("iss9",       0, 9, 0, 0, 32'h0,        1, 9, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("rd9_busy",   0, 9, 0, 0, 32'h0,        0, 0, 0, 32'h0, 32'h0, 0, 1, 0));

    $display("[TB] reset and basic vectors");
    runVec(tbl[0]);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i < tbl.size(); i++) begin
      runVec(tbl[i]);
    end

    $display("[TB] filling x1..x31");
    for (int i = 1; i < 32; i++) begin
      runVec(mk("fill", 5'(i - 1), 0, 1, 5'(i), fillVal(i), (i == 10), 4, 0,
                (i == 1) ? 32'h0 : fillVal(i - 1), 32'h0, 0, 0, 0));
    end
    runVec(mk("clr_start", 4, 9, 0, 0, 32'h0, 0, 0, 1, fillVal(4), fillVal(9), 1, 0, 0));

    $display("[TB] clear sequence with ignored write/issue/restart");
    for (int c = 1; c <= 31; c++) begin
      runVec(mk("clearing", 5'(c - 1), 31, 1, 31, 32'hFFFFFFFF, 1, 31, 1,
                32'h0, fillVal(31), 0, 0, 1));
    end
    runVec(mk("clr_done", 31, 4, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    runVec(mk("wr31_after", 30, 1, 1, 31, 32'h31313131, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    runVec(mk("rd31_after", 31, 20, 0, 0, 32'h0, 0, 0, 0, 32'h31313131, 32'h0, 0, 0, 0));
    for (int i = 1; i < 31; i++) begin
      runVec(mk("all_zero", 5'(i), 9, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    end

    $display("[TB] reset during clear");
    runVec(mk("wr20", 31, 0, 1, 20, 32'h20202020, 0, 0, 0, 32'h31313131, 32'h0, 0, 0, 0));
    runVec(mk("clr2_start", 20, 31, 0, 0, 32'h0, 0, 0, 1, 32'h20202020, 32'h31313131, 0, 0, 0));
    for (int c = 1; c <= 10; c++) begin
      runVec(mk("clearing2", 20, 31, 0, 0, 32'h0, 0, 0, 0, 32'h20202020, 32'h31313131, 0, 0, 1));
    end
    begin
      exp_t e;
      e.name = "mid_reset";
      e.d0 = 32'h0; e.d1 = 32'h0; e.nd0 = 32'h0; e.nd1 = 32'h0;
      e.b0 = 1'b0; e.b1 = 1'b0; e.nb0 = 1'b0; e.nb1 = 1'b0; e.cb = 1'b0;
      sb_q.push_back(e);
      reset = 1'b0;
      checkOutput();
    end
    @(negedge clk);
    reset = 1'b1;
    runVec(mk("post_rst_wr6", 20, 31, 1, 6, 32'h00000066, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    runVec(mk("post_rst_rd6", 6, 20, 0, 0, 32'h0, 0, 0, 0, 32'h00000066, 32'h0, 0, 0, 0));

    if (sb_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
